// File: rtl/flipflop_i_latch.sv
// flipflop_i_latch
// Holds the "I" micro-state register fed by the FLIPFLOP_I encoder stage.
// A two-state P1/P2 phase sequencer gates when a new code may be captured:
// captures happen only on an edge taken from P2, only when a P2_Set_* request
// is present, and never while stalled. A sticky error flag reports encoder
// output that is inconsistent with the set request.
// Optional feature: define FLIPFLOP_I_HISTORY_EN to keep a circular history of
// the codes that captures have replaced. i_prev then exposes the most recently
// replaced code. Without the macro, i_prev is tied to zero.

module flipflop_i_latch #(
    parameter int W = 8,
    parameter logic [W-1:0] IDLE_CODE = '0
`ifdef FLIPFLOP_I_HISTORY_EN
    ,
    parameter int HIST_DEPTH = 4
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         set_any,
    input  logic [W-1:0] encoded,
    input  logic         err_clr,
    output logic         phase_p1,
    output logic         phase_p2,
    output logic [W-1:0] i_q,
    output logic         i_valid,
    output logic         i_load,
    output logic         err,
    output logic [W-1:0] i_prev
);

    typedef enum logic {
        PH_P1 = 1'b0,
        PH_P2 = 1'b1
    } phase_t;

    phase_t       phase_q;
    phase_t       phase_d;
    logic [W-1:0] i_d;
    logic         i_load_q;
    logic         i_load_d;
    logic         err_q;
    logic         err_d;

    logic         capture_window;
    logic         do_capture;
    logic         fault;

    // The capture window is an unstalled, unflushed edge taken from P2; the
    // consistency check only looks at the encoder during that window.
    always_comb begin
        capture_window = 1'b0;
        do_capture     = 1'b0;
        fault          = 1'b0;
        capture_window = (phase_q == PH_P2) && !stall && !flush;
        do_capture     = capture_window && set_any;
        fault          = capture_window &&
                         ((!set_any && (encoded != '0)) ||
                          ( set_any && (encoded == IDLE_CODE)));
    end

    // Phase sequencer next state: alternate each edge, freeze while stalled.
    always_comb begin
        phase_d = phase_q;
        if (!stall) begin
            case (phase_q)
                PH_P1:   phase_d = PH_P2;
                PH_P2:   phase_d = PH_P1;
                default: phase_d = PH_P1;
            endcase
        end
    end

    // I register next value: flush wins at any edge, otherwise capture the
    // encoder output; a faulty capture still loads whatever was presented.
    always_comb begin
        i_d = i_q;
        if (flush) begin
            i_d = IDLE_CODE;
        end else if (do_capture) begin
            i_d = encoded;
        end
    end

    // Load pulse marks the cycle following any capture, including rewrites
    // of an identical code.
    always_comb begin
        i_load_d = 1'b0;
        i_load_d = do_capture;
    end

    // Sticky error: a new fault beats a simultaneous clear request.
    always_comb begin
        err_d = err_q;
        if (fault) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // State registers for the sequencer, the I code, the load pulse and err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q  <= PH_P1;
            i_q      <= IDLE_CODE;
            i_load_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            i_q      <= i_d;
            i_load_q <= i_load_d;
            err_q    <= err_d;
        end
    end

    // Outputs are taken straight from the flops so they are glitch-free and
    // follow reset immediately.
    always_comb begin
        phase_p1 = (phase_q == PH_P1);
        phase_p2 = (phase_q == PH_P2);
        i_valid  = (i_q != IDLE_CODE);
        i_load   = i_load_q;
        err      = err_q;
    end

`ifdef FLIPFLOP_I_HISTORY_EN
    localparam int PTR_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(HIST_DEPTH - 1);

    logic [W-1:0]     hist_q [HIST_DEPTH];
    logic [W-1:0]     hist_d [HIST_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] last_ptr;

    // On each capture, push the code being replaced and advance the pointer,
    // wrapping so the oldest entry is overwritten. Flush never pushes.
    always_comb begin
        hist_d   = hist_q;
        wr_ptr_d = wr_ptr_q;
        if (do_capture) begin
            hist_d[wr_ptr_q] = i_q;
            wr_ptr_d         = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + PTR_W'(1);
        end
    end

    // History buffer and write pointer storage, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < HIST_DEPTH; k++) begin
                hist_q[k] <= '0;
            end
            wr_ptr_q <= '0;
        end else begin
            hist_q   <= hist_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // The newest entry sits one slot behind the write pointer; after reset
    // that slot is cleared, so i_prev reads zero until the first push.
    always_comb begin
        last_ptr = (wr_ptr_q == '0) ? LAST_SLOT : wr_ptr_q - PTR_W'(1);
        i_prev   = hist_q[last_ptr];
    end
`else
    // History disabled: nothing to report.
    always_comb begin
        i_prev = '0;
    end
`endif

endmodule

// File: tb/tb_flipflop_i_latch.sv
// Testbench for flipflop_i_latch. Random and directed stimulus is compared
// against a behavioural model of the I latch; define FLIPFLOP_I_HISTORY_EN
// for both files to cover the history feature.

module tb_flipflop_i_latch;

    logic       clk;
    logic       rst;
    logic       stall;
    logic       flush;
    logic       set_any;
    logic [7:0] encoded;
    logic       err_clr;
    logic       phase_p1;
    logic       phase_p2;
    logic [7:0] i_q;
    logic       i_valid;
    logic       i_load;
    logic       err;
    logic [7:0] i_prev;

    int passed = 0;
    int total  = 0;

    // Behavioural model state: m_in_p2 is 1 while the sequencer sits in P2.
    bit         m_in_p2;
    logic [7:0] m_iq;
    logic       m_load;
    logic       m_err;
    logic [7:0] m_hist[$];

    flipflop_i_latch dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .set_any  (set_any),
        .encoded  (encoded),
        .err_clr  (err_clr),
        .phase_p1 (phase_p1),
        .phase_p2 (phase_p2),
        .i_q      (i_q),
        .i_valid  (i_valid),
        .i_load   (i_load),
        .err      (err),
        .i_prev   (i_prev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] m_prev();
`ifdef FLIPFLOP_I_HISTORY_EN
        return (m_hist.size() > 0) ? m_hist[$] : 8'h00;
`else
        return 8'h00;
`endif
    endfunction

    task automatic m_reset();
        m_in_p2 = 1'b0;
        m_iq    = 8'h00;
        m_load  = 1'b0;
        m_err   = 1'b0;
        m_hist.delete();
    endtask

    // Drive one cycle of inputs, let the edge happen, advance the model from
    // the pre-edge state, then land on the falling edge for sampling.
    task automatic cycle(input logic st, input logic fl, input logic sa,
                         input logic [7:0] enc, input logic ec);
        bit window;
        stall   = st;
        flush   = fl;
        set_any = sa;
        encoded = enc;
        err_clr = ec;
        @(posedge clk);
        window = m_in_p2 && !st && !fl;
        if (window && ((!sa && enc != 8'h00) || (sa && enc == 8'h00)))
            m_err = 1'b1;
        else if (ec)
            m_err = 1'b0;
        m_load = window && sa;
        if (fl) begin
            m_iq = 8'h00;
        end else if (m_load) begin
            m_hist.push_back(m_iq);
            m_iq = enc;
        end
        if (!st) m_in_p2 = !m_in_p2;
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic go_to_p2();
        for (int n = 0; n < 2; n++) begin
            if (!m_in_p2) idle();
        end
    endtask

    task automatic capture(input logic [7:0] code);
        go_to_p2();
        cycle(1'b0, 1'b0, 1'b1, code, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; flush = 0; set_any = 0; encoded = 0; err_clr = 0;
        m_reset();
        #3;
        total++; if (phase_p1 !== 1'b1) $display("[TB] FAIL rst_p1: got %b expected 1", phase_p1); else passed++;
        total++; if (phase_p2 !== 1'b0) $display("[TB] FAIL rst_p2: got %b expected 0", phase_p2); else passed++;
        total++; if (i_q !== 8'h00) $display("[TB] FAIL rst_iq: got %h expected 00", i_q); else passed++;
        total++; if ({i_valid, i_load, err} !== 3'b000) $display("[TB] FAIL rst_flags: got %b expected 000", {i_valid, i_load, err}); else passed++;
        total++; if (i_prev !== 8'h00) $display("[TB] FAIL rst_prev: got %h expected 00", i_prev); else passed++;
        @(negedge clk);
        rst = 1'b0;
        idle();
        total++; if (phase_p2 !== 1'b1) $display("[TB] FAIL rst_first_phase: got %b expected 1", phase_p2); else passed++;
    endtask

    task automatic test_capture();
        capture(8'hFA);
        total++; if (i_q !== 8'hFA) $display("[TB] FAIL cap_iq: got %h expected fa", i_q); else passed++;
        total++; if (i_load !== 1'b1) $display("[TB] FAIL cap_load: got %b expected 1", i_load); else passed++;
        total++; if (i_valid !== 1'b1) $display("[TB] FAIL cap_valid: got %b expected 1", i_valid); else passed++;
        total++; if (phase_p1 !== 1'b1) $display("[TB] FAIL cap_phase: got %b expected 1", phase_p1); else passed++;
        idle();
        total++; if (i_load !== 1'b0) $display("[TB] FAIL cap_load_pulse: got %b expected 0", i_load); else passed++;
        capture(8'hFA);
        total++; if (i_load !== 1'b1) $display("[TB] FAIL same_value_load: got %b expected 1", i_load); else passed++;
    endtask

    task automatic test_stall();
        go_to_p2();
        for (int n = 0; n < 3; n++) begin
            cycle(1'b1, 1'b0, 1'b1, 8'h48, 1'b0);
            total++; if (i_q !== m_iq || i_q === 8'h48) $display("[TB] FAIL stall_iq: got %h expected %h", i_q, m_iq); else passed++;
            total++; if (phase_p2 !== 1'b1) $display("[TB] FAIL stall_frozen: got %b expected 1", phase_p2); else passed++;
            total++; if (i_load !== 1'b0) $display("[TB] FAIL stall_load: got %b expected 0", i_load); else passed++;
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h48, 1'b0);
        total++; if (i_q !== 8'h48) $display("[TB] FAIL stall_release_iq: got %h expected 48", i_q); else passed++;
        total++; if (i_load !== 1'b1) $display("[TB] FAIL stall_release_load: got %b expected 1", i_load); else passed++;
    endtask

    task automatic test_flush_priority();
        go_to_p2();
        cycle(1'b0, 1'b1, 1'b1, 8'h9F, 1'b0);
        total++; if (i_q !== 8'h00) $display("[TB] FAIL flush_iq: got %h expected 00", i_q); else passed++;
        total++; if (i_load !== 1'b0) $display("[TB] FAIL flush_load: got %b expected 0", i_load); else passed++;
        total++; if (err !== 1'b0) $display("[TB] FAIL flush_err: got %b expected 0", err); else passed++;
        total++; if (i_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", i_valid); else passed++;
        capture(8'h5A);
        idle();
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (i_q !== 8'h00) $display("[TB] FAIL flush_p1_iq: got %h expected 00", i_q); else passed++;
        total++; if (phase_p1 !== 1'b1) $display("[TB] FAIL flush_p1_phase: got %b expected 1", phase_p1); else passed++;
    endtask

    task automatic test_err();
        go_to_p2();
        cycle(1'b0, 1'b0, 1'b0, 8'h08, 1'b0);
        total++; if (err !== 1'b1) $display("[TB] FAIL err_spurious: got %b expected 1", err); else passed++;
        idle();
        idle();
        total++; if (err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", err); else passed++;
        go_to_p2();
        cycle(1'b0, 1'b0, 1'b0, 8'h08, 1'b1);
        total++; if (err !== 1'b1) $display("[TB] FAIL err_clr_vs_fault: got %b expected 1", err); else passed++;
        cycle(1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
        total++; if (err !== 1'b0) $display("[TB] FAIL err_clr_p1: got %b expected 0", err); else passed++;
        cycle(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        total++; if (err !== 1'b1) $display("[TB] FAIL err_no_code: got %b expected 1", err); else passed++;
    endtask

    task automatic test_async_reset_mid_p2();
        capture(8'hC8);
        go_to_p2();
        total++; if (i_q !== 8'hC8) $display("[TB] FAIL pre_reset_iq: got %h expected c8", i_q); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (i_q !== 8'h00) $display("[TB] FAIL async_iq: got %h expected 00", i_q); else passed++;
        total++; if (phase_p1 !== 1'b1) $display("[TB] FAIL async_p1: got %b expected 1", phase_p1); else passed++;
        total++; if (err !== 1'b0) $display("[TB] FAIL async_err: got %b expected 0", err); else passed++;
        #1 rst = 1'b0;
        m_reset();
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes[5];
        codes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (codes[k]) capture(codes[k]);
        total++; if (i_q !== 8'h55) $display("[TB] FAIL hist_iq: got %h expected 55", i_q); else passed++;
`ifdef FLIPFLOP_I_HISTORY_EN
        total++; if (i_prev !== 8'h44) $display("[TB] FAIL hist_prev: got %h expected 44", i_prev); else passed++;
`else
        total++; if (i_prev !== 8'h00) $display("[TB] FAIL hist_prev_off: got %h expected 00", i_prev); else passed++;
`endif
        cycle(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        total++; if (i_prev !== m_prev()) $display("[TB] FAIL hist_flush_prev: got %h expected %h", i_prev, m_prev()); else passed++;
        total++; if (i_q !== 8'h00) $display("[TB] FAIL hist_flush_iq: got %h expected 00", i_q); else passed++;
    endtask

    task automatic test_random();
        logic       st, fl, sa, ec;
        logic [7:0] enc;
        for (int n = 0; n < 400; n++) begin
            st  = ($urandom_range(0, 4) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            sa  = 1'($urandom_range(0, 1));
            ec  = ($urandom_range(0, 5) == 0);
            if (sa) enc = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            else    enc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            cycle(st, fl, sa, enc, ec);
            total++; if ({phase_p1, phase_p2} !== {!m_in_p2, m_in_p2}) $display("[TB] FAIL rnd_phase: got %b%b expected %b%b", phase_p1, phase_p2, !m_in_p2, m_in_p2); else passed++;
            total++; if (i_q !== m_iq) $display("[TB] FAIL rnd_iq: got %h expected %h", i_q, m_iq); else passed++;
            total++; if (i_valid !== (m_iq != 8'h00)) $display("[TB] FAIL rnd_valid: got %b expected %b", i_valid, (m_iq != 8'h00)); else passed++;
            total++; if (i_load !== m_load) $display("[TB] FAIL rnd_load: got %b expected %b", i_load, m_load); else passed++;
            total++; if (err !== m_err) $display("[TB] FAIL rnd_err: got %b expected %b", err, m_err); else passed++;
            total++; if (i_prev !== m_prev()) $display("[TB] FAIL rnd_prev: got %h expected %h", i_prev, m_prev()); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_stall();
        test_flush_priority();
        test_err();
        test_async_reset_mid_p2();
        test_back_to_back();
        test_random();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
